adpll_lock_controller: RTL and testbench

//   Sequences the ADPLL phase-detector measurement and feeds the loop filter.
//   - Detects each reference_i rising edge and waits for the phase-detector count to settle.
//   - Samples the signed pd_clock_cycles value and issues one update strobe per reference period.
//   - Runs the acquire/track lock state machine and selects the loop-filter gain (coarse/fine).
//   - Sits between PhaseDetector (pd_clock_cycles_o) and the loop filter/DCO, in the fpga_clk domain.

---
 rtl/adpll_lock_controller.sv | 219 +++++++++++++++++++++
 tb/tb_adpll_lock_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_controller.sv
// ADPLL lock controller: times each phase-detector sample off the reference edge and runs
// the acquire/track lock state machine that picks the loop-filter gain.
module adpll_lock_controller #(
  parameter int WIDTH         = 20,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_THRESH   = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             reference_i,
  input  logic [WIDTH-1:0] pd_clock_cycles_i,
  output logic             update_o,
  output logic [WIDTH-1:0] error_o,
  output logic [1:0]       gain_sel_o,
  output logic             locked_o,
  output logic             overrun_o,
  output logic [1:0]       state_o
);

  localparam int MAX_A = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [1:0] GAIN_HOLD   = 2'b00;
  localparam logic [1:0] GAIN_COARSE = 2'b01;
  localparam logic [1:0] GAIN_FINE   = 2'b10;

  localparam logic [CW-1:0]    CNT_ZERO   = CW'(32'd0);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(32'd1);
  localparam logic [CW-1:0]    SETTLE_LD  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]    LOCK_LIM   = CW'(LOCK_COUNT);
  localparam logic [CW-1:0]    UNLOCK_LIM = CW'(UNLOCK_COUNT);
  localparam logic [WIDTH-1:0] THRESH     = WIDTH'(LOCK_THRESH);

  // Two's-complement magnitude; the most negative code has no positive twin, so clamp it.
  function automatic logic [WIDTH-1:0] abs_sat(input logic [WIDTH-1:0] e);
    logic [WIDTH-1:0] neg;
    neg = ~e + {{(WIDTH-1){1'b0}}, 1'b1};
    if (!e[WIDTH-1]) begin
      abs_sat = e;
    end else if (neg[WIDTH-1]) begin
      abs_sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      abs_sat = neg;
    end
  endfunction

  logic             sync1_q, sync2_q, sync3_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             update_q, update_d;
  logic [WIDTH-1:0] error_q, error_d;
  logic [1:0]       gain_sel_q, gain_sel_d;
  logic             locked_q, locked_d;
  logic             overrun_q, overrun_d;

  logic             rise_det_s;
  logic             active_s;
  logic             load_s;
  logic             ovr_s;
  logic             sample_s;
  logic             in_win_s;

  always_comb begin
    rise_det_s = sync2_q & ~sync3_q;
    active_s   = enable_i && ((state_q == ST_ACQ) || (state_q == ST_TRACK));
    load_s     = active_s && rise_det_s && (cnt_q <= CNT_ONE);
    ovr_s      = active_s && rise_det_s && (cnt_q > CNT_ONE);
    in_win_s   = (abs_sat(pd_clock_cycles_i) <= THRESH);

    // The sample edge is the one on which the settle count lands on 1, so update_o
    // rises exactly SETTLE_CYCLES cycles after rise_det, even when SETTLE_CYCLES is 1.
    if (!active_s) begin
      cnt_d = CNT_ZERO;
    end else if (load_s) begin
      cnt_d = SETTLE_LD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
    sample_s = active_s && (cnt_d == CNT_ONE);

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    miss_cnt_d = miss_cnt_q;
    overrun_d  = overrun_q;
    update_d   = 1'b0;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        lock_cnt_d = CNT_ZERO;
        miss_cnt_d = CNT_ZERO;
        overrun_d  = 1'b0;
        if (enable_i) begin
          state_d = ST_ACQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACQ: begin
        overrun_d = overrun_q | ovr_s;
        if (sample_s) begin
          update_d = 1'b1;
          error_d  = pd_clock_cycles_i;
          if (!in_win_s) begin
            lock_cnt_d = CNT_ZERO;
          end else if (lock_cnt_q + CNT_ONE >= LOCK_LIM) begin
            lock_cnt_d = LOCK_LIM;
            miss_cnt_d = CNT_ZERO;
            state_d    = ST_TRACK;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end else begin
          update_d = 1'b0;
        end
      end
      ST_TRACK: begin
        overrun_d = overrun_q | ovr_s;
        if (sample_s) begin
          update_d = 1'b1;
          error_d  = pd_clock_cycles_i;
          if (in_win_s) begin
            miss_cnt_d = CNT_ZERO;
          end else if (miss_cnt_q + CNT_ONE >= UNLOCK_LIM) begin
            miss_cnt_d = CNT_ZERO;
            lock_cnt_d = CNT_ZERO;
            state_d    = ST_ACQ;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
          end
        end else begin
          update_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = CNT_ZERO;
        miss_cnt_d = CNT_ZERO;
        overrun_d  = 1'b0;
      end
    endcase

    // Dropping enable wins over everything above, including a sample due on this edge.
    if (!enable_i) begin
      state_d    = ST_IDLE;
      lock_cnt_d = CNT_ZERO;
      miss_cnt_d = CNT_ZERO;
      overrun_d  = 1'b0;
      update_d   = 1'b0;
    end else begin
      state_d = state_d;
    end

    case (state_d)
      ST_ACQ: begin
        gain_sel_d = GAIN_COARSE;
        locked_d   = 1'b0;
      end
      ST_TRACK: begin
        gain_sel_d = GAIN_FINE;
        locked_d   = 1'b1;
      end
      default: begin
        gain_sel_d = GAIN_HOLD;
        locked_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      cnt_q      <= CNT_ZERO;
      state_q    <= ST_IDLE;
      lock_cnt_q <= CNT_ZERO;
      miss_cnt_q <= CNT_ZERO;
      update_q   <= 1'b0;
      error_q    <= {WIDTH{1'b0}};
      gain_sel_q <= GAIN_HOLD;
      locked_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= reference_i;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      update_q   <= update_d;
      error_q    <= error_d;
      gain_sel_q <= gain_sel_d;
      locked_q   <= locked_d;
      overrun_q  <= overrun_d;
    end
  end

  assign update_o   = update_q;
  assign error_o    = error_q;
  assign gain_sel_o = gain_sel_q;
  assign locked_o   = locked_q;
  assign overrun_o  = overrun_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adpll_lock_controller.sv
// Bench for adpll_lock_controller: directed scenarios plus randomized reference periods,
// every cycle compared against an event-time reference model.
module tb_adpll_lock_controller;

  localparam int WIDTH = 20;
  localparam int S     = 4;
  localparam int TH    = 8;
  localparam int LC    = 16;
  localparam int UC    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             refc = 1'b0;
  logic [WIDTH-1:0] pd = '0;
  logic             update_o;
  logic [WIDTH-1:0] error_o;
  logic [1:0]       gain_sel_o;
  logic             locked_o;
  logic             overrun_o;
  logic [1:0]       state_o;

  always #5 clk = ~clk;

  adpll_lock_controller #(
    .WIDTH(WIDTH), .SETTLE_CYCLES(S), .LOCK_THRESH(TH),
    .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)
  ) dut (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .reference_i(refc),
    .pd_clock_cycles_i(pd), .update_o(update_o), .error_o(error_o),
    .gain_sel_o(gain_sel_o), .locked_o(locked_o), .overrun_o(overrun_o),
    .state_o(state_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: tracks when each reference rise is seen and when its sample is due.
  int               t = 0;
  int               m_state, m_lock, m_miss, m_pending;
  bit               m_update, m_overrun, prev_ref;
  logic [WIDTH-1:0] m_error;
  int               rq[$];
  int               upd_cnt = 0;

  task automatic model_reset();
    m_state = 0; m_lock = 0; m_miss = 0; m_pending = -1;
    m_update = 0; m_overrun = 0; prev_ref = 0; m_error = '0;
    rq.delete();
  endtask

  task automatic do_sample();
    int e, mag;
    bit inwin;
    m_update = 1;
    m_error  = pd;
    e   = int'($signed(pd));
    mag = (e < 0) ? -e : e;
    if (mag > (1 << (WIDTH-1)) - 1) mag = (1 << (WIDTH-1)) - 1;
    inwin = (mag <= TH);
    if (m_state == 1) begin
      if (inwin) begin
        m_lock++;
        if (m_lock >= LC) begin m_state = 2; m_miss = 0; end
      end else m_lock = 0;
    end else begin
      if (inwin) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss >= UC) begin m_state = 1; m_lock = 0; m_miss = 0; end
      end
    end
  endtask

  task automatic model_step();
    bit rise_now;
    rise_now = 0;
    // A level change seen at edge t becomes rise_det after the synchroniser and acts at t+2.
    if (refc && !prev_ref) rq.push_back(t + 2);
    prev_ref = refc;
    if (rq.size() > 0 && rq[0] == t) begin rise_now = 1; void'(rq.pop_front()); end
    m_update = 0;
    if (!en) begin
      m_state = 0; m_pending = -1; m_overrun = 0; m_lock = 0; m_miss = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_pending = -1; m_overrun = 0;
    end else begin
      if (rise_now) begin
        if (m_pending >= 0 && t <= m_pending) m_overrun = 1;
        else m_pending = t + S - 1;
      end
      if (m_pending == t) begin m_pending = -1; do_sample(); end
    end
  endtask

  task automatic compare_all();
    check_val("update",  update_o,   m_update);
    check_val("error",   error_o,    m_error);
    check_val("gain",    gain_sel_o, m_state);
    check_val("locked",  locked_o,   (m_state == 2));
    check_val("overrun", overrun_o,  m_overrun);
    check_val("state",   state_o,    m_state);
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
    if (update_o) upd_cnt++;
  endtask

  // One reference period: high for the first half, pd held at v throughout.
  task automatic ref_period(input int per, input logic [WIDTH-1:0] v,
                            output int lat, output logic lk, output logic [1:0] gs);
    pd = v; lat = -1; lk = 1'b0; gs = 2'b00;
    for (int i = 1; i <= per; i++) begin
      refc = (i <= per / 2);
      tick();
      if (update_o && lat < 0) begin lat = i; lk = locked_o; gs = gain_sel_o; end
    end
    refc = 1'b0;
  endtask

  int lat;
  logic lk;
  logic [1:0] gs;
  int base;
  int iv;
  logic [WIDTH-1:0] rv;

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0; en = 1'b1;
    tick();
    check_val("enter_acq", state_o, 32'd1);

    // Lock acquisition at 80-cycle period; latency 6 = 2 sync stages + 4 settle cycles.
    for (int j = 1; j <= LC; j++) begin
      ref_period(80, 20'd0, lat, lk, gs);
      check_val("latency", lat, 32'd6);
      check_val("lock_at_upd", lk, (j == LC));
    end
    check_val("lock_gain", gs, 32'd2);

    // Short runs out of window keep lock; the fourth in a row drops it.
    for (int j = 0; j < 3; j++) begin
      ref_period(20, 20'd9, lat, lk, gs);
      check_val("track_hold", lk, 32'd1);
    end
    ref_period(20, 20'd0, lat, lk, gs);
    for (int j = 1; j <= UC; j++) ref_period(20, 20'd9, lat, lk, gs);
    check_val("unlock_locked", lk, 32'd0);
    check_val("unlock_gain", gs, 32'd1);
    check_val("unlock_err", error_o, 32'd9);
    check_val("unlock_state", state_o, 32'd1);

    // Boundary values: -8 is in-window, most negative code is out of window.
    for (int j = 0; j < 10; j++) ref_period(20, 20'hFFFF8, lat, lk, gs);
    check_val("neg8_err", error_o, 32'hFFFF8);
    ref_period(20, 20'h80000, lat, lk, gs);
    check_val("minneg_err", error_o, 32'h80000);
    for (int j = 0; j < LC - 1; j++) ref_period(20, 20'hFFFF8, lat, lk, gs);
    check_val("relock_not_yet", locked_o, 32'd0);
    ref_period(20, 20'd8, lat, lk, gs);
    check_val("relock", locked_o, 32'd1);

    // Two edges three cycles apart: one update, sticky overrun.
    pd = 20'd0; base = upd_cnt;
    refc = 1'b1; tick(); refc = 1'b0; tick(); tick(); refc = 1'b1; tick(); refc = 1'b0;
    repeat (16) tick();
    check_val("dbl_updates", upd_cnt - base, 32'd1);
    check_val("dbl_overrun", overrun_o, 32'd1);
    ref_period(20, 20'd0, lat, lk, gs);
    ref_period(20, 20'd0, lat, lk, gs);
    check_val("overrun_sticky", overrun_o, 32'd1);
    en = 1'b0; tick(); tick();
    check_val("overrun_clr", overrun_o, 32'd0);

    // Enable drop two cycles after rise_det aborts the pending sample.
    en = 1'b1; tick();
    base = upd_cnt;
    refc = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) refc = 1'b0;
      if (i == 5) en = 1'b0;
      tick();
    end
    check_val("abort_updates", upd_cnt - base, 32'd0);
    check_val("abort_state", state_o, 32'd0);
    check_val("abort_gain", gain_sel_o, 32'd0);
    check_val("abort_overrun", overrun_o, 32'd0);

    // Asynchronous reset in the middle of a settle while tracking.
    en = 1'b1; tick();
    for (int j = 0; j < LC; j++) ref_period(20, 20'd1, lat, lk, gs);
    check_val("pre_rst_track", state_o, 32'd2);
    pd = 20'd5; refc = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_val("rst_update", update_o, 32'd0);
    check_val("rst_error", error_o, 32'd0);
    check_val("rst_gain", gain_sel_o, 32'd0);
    check_val("rst_locked", locked_o, 32'd0);
    check_val("rst_overrun", overrun_o, 32'd0);
    check_val("rst_state", state_o, 32'd0);
    refc = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("post_rst_acq", state_o, 32'd1);

    // Randomized periods, values and occasional enable drops / double edges.
    for (int k = 0; k < 70; k++) begin
      case ($urandom_range(0, 6))
        0, 1, 2, 3: begin iv = int'($urandom_range(0, 16)) - 8; rv = iv[WIDTH-1:0]; end
        4: begin iv = ($urandom_range(0, 1) != 0) ? 9 : -9; rv = iv[WIDTH-1:0]; end
        5: rv = 20'h80000;
        default: begin iv = int'($urandom); rv = iv[WIDTH-1:0]; end
      endcase
      if ($urandom_range(0, 14) == 0) begin
        en = 1'b0; repeat ($urandom_range(1, 4)) tick(); en = 1'b1;
      end else if ($urandom_range(0, 9) == 0) begin
        pd = rv; refc = 1'b1; tick(); refc = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
      end else begin
        iv = 0;
      end
      ref_period(int'($urandom_range(10, 40)), rv, lat, lk, gs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
